// File: rtl/lockpick_pkg.sv
// Shared types and constants for the lockpick frame loader.
package lockpick_pkg;

    // Loader FSM states: receive a frame, then replay it into the game.
    typedef enum logic [2:0] {
        WAIT_SOF   = 3'd0,
        RX_PAYLOAD = 3'd1,
        RX_CSUM    = 3'd2,
        WAIT_GAME  = 3'd3,
        START      = 3'd4,
        SEND       = 3'd5
    } loader_state_e;

    // lockpick_game status encodings.
    localparam logic [1:0] STAT_IDLE = 2'b00;
    localparam logic [1:0] STAT_ERR  = 2'b01;
    localparam logic [1:0] STAT_WIN  = 2'b10;
    localparam logic [1:0] STAT_LOCK = 2'b11;

    localparam logic [7:0] SOF_BYTE_DEFAULT = 8'hA5;

    // True in the states where the loader listens to the host link.
    function automatic logic is_rx_state(input loader_state_e s);
        return (s == WAIT_SOF) || (s == RX_PAYLOAD) || (s == RX_CSUM);
    endfunction

endpackage

// File: rtl/lockpick_payload_buf.sv
// Single-frame payload store: one write port, one registered read port.
// Storage itself is not reset; only the read register is.
module lockpick_payload_buf #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data
);

    logic [7:0] mem_q [DEPTH];
    logic [7:0] rd_data_q;
    logic [7:0] rd_data_d;

    // Byte storage, written while a frame is being received.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Read data is forced to zero whenever no byte is being replayed.
    always_comb begin
        rd_data_d = rd_en ? mem_q[rd_addr] : 8'h00;
    end

    // Registered read port, cleared asynchronously so the game pins drop on reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data_q <= 8'h00;
        end else begin
            rd_data_q <= rd_data_d;
        end
    end

    assign rd_data = rd_data_q;

endmodule

// File: rtl/lockpick_frame_loader.sv
// Receives one framed, XOR-checksummed key frame from the host link and
// replays it into lockpick_game once the game is ready for input.
//
// Host handshake: a byte transfers on a rising clk edge where rx_valid and
// rx_ready are both high; rx_ready is only high while the loader is
// receiving, so the single buffer is never overwritten during replay.
module lockpick_frame_loader
    import lockpick_pkg::*;
#(
    parameter int         PAYLOAD_BYTES = 64,
    parameter logic [7:0] SOF_BYTE      = SOF_BYTE_DEFAULT,
    parameter int         RX_TIMEOUT    = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_valid,
    input  logic [7:0] rx_data,
    output logic       rx_ready,
    input  logic       game_output_valid,
    input  logic [1:0] game_status,
    output logic       game_start,
    output logic       game_input_enable,
    output logic [7:0] game_input_data,
    output logic       frame_err,
    output logic       busy,
    output logic [2:0] dbg_state
);

    localparam int IDX_W  = $clog2(PAYLOAD_BYTES) + 1;
    localparam int ADDR_W = $clog2(PAYLOAD_BYTES);
    localparam int IDLE_W = $clog2(RX_TIMEOUT + 1);

    localparam logic [IDX_W-1:0]  LAST_IDX   = IDX_W'(PAYLOAD_BYTES - 1);
    localparam logic [IDX_W-1:0]  SEND_LEN   = IDX_W'(PAYLOAD_BYTES);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(RX_TIMEOUT);

    loader_state_e     state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [7:0]        csum_q, csum_d;
    logic [IDLE_W-1:0] idle_q, idle_d, idle_inc;
    logic [IDX_W-1:0]  send_cnt_q, send_cnt_d;
    logic              game_busy_q, game_busy_d;
    logic              ov_prev_q;
    logic              frame_err_q, frame_err_d;
    logic              rx_ready_q, rx_ready_d;
    logic              game_start_q, game_start_d;
    logic              input_enable_q, input_enable_d;

    logic              rx_accept;
    logic              buf_wr_en;
    logic              buf_rd_en;
    logic [ADDR_W-1:0] buf_rd_addr;

    assign rx_accept = rx_valid && rx_ready_q;
    assign idle_inc  = (idle_q == IDLE_LIMIT) ? idle_q : idle_q + IDLE_W'(1);

    lockpick_payload_buf #(
        .DEPTH  (PAYLOAD_BYTES),
        .ADDR_W (ADDR_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (buf_wr_en),
        .wr_addr (idx_q[ADDR_W-1:0]),
        .wr_data (rx_data),
        .rd_en   (buf_rd_en),
        .rd_addr (buf_rd_addr),
        .rd_data (game_input_data)
    );

    // State register and all loader flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q        <= WAIT_SOF;
            idx_q          <= '0;
            csum_q         <= 8'h00;
            idle_q         <= '0;
            send_cnt_q     <= '0;
            game_busy_q    <= 1'b0;
            ov_prev_q      <= 1'b0;
            frame_err_q    <= 1'b0;
            rx_ready_q     <= 1'b0;
            game_start_q   <= 1'b0;
            input_enable_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            csum_q         <= csum_d;
            idle_q         <= idle_d;
            send_cnt_q     <= send_cnt_d;
            game_busy_q    <= game_busy_d;
            ov_prev_q      <= game_output_valid;
            frame_err_q    <= frame_err_d;
            rx_ready_q     <= rx_ready_d;
            game_start_q   <= game_start_d;
            input_enable_q <= input_enable_d;
        end
    end

    // Next-state logic: frame reception, checksum/timeout, and replay sequencing.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        csum_d      = csum_q;
        idle_d      = '0;
        send_cnt_d  = send_cnt_q;
        frame_err_d = 1'b0;
        buf_wr_en   = 1'b0;
        buf_rd_en   = 1'b0;
        buf_rd_addr = send_cnt_q[ADDR_W-1:0];
        case (state_q)
            WAIT_SOF: begin
                if (rx_accept && (rx_data == SOF_BYTE)) begin
                    state_d = RX_PAYLOAD;
                    idx_d   = '0;
                    csum_d  = 8'h00;
                end
            end
            RX_PAYLOAD: begin
                if (rx_accept) begin
                    buf_wr_en = 1'b1;
                    csum_d    = csum_q ^ rx_data;
                    idx_d     = idx_q + IDX_W'(1);
                    if (idx_q == LAST_IDX) begin
                        state_d = RX_CSUM;
                    end
                end else if (idle_inc == IDLE_LIMIT) begin
                    frame_err_d = 1'b1;
                    state_d     = WAIT_SOF;
                end else begin
                    idle_d = idle_inc;
                end
            end
            RX_CSUM: begin
                if (rx_accept) begin
                    if (rx_data == csum_q) begin
                        state_d    = WAIT_GAME;
                        send_cnt_d = '0;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = WAIT_SOF;
                    end
                end else if (idle_inc == IDLE_LIMIT) begin
                    frame_err_d = 1'b1;
                    state_d     = WAIT_SOF;
                end else begin
                    idle_d = idle_inc;
                end
            end
            WAIT_GAME: begin
                if (!game_busy_q) begin
                    case (game_status)
                        STAT_ERR: begin
                            // Game is retrying and already expects key bytes.
                            state_d    = SEND;
                            buf_rd_en  = 1'b1;
                            send_cnt_d = IDX_W'(1);
                        end
                        STAT_IDLE: state_d = START;
                        default:   state_d = WAIT_GAME;
                    endcase
                end
            end
            START: begin
                state_d    = SEND;
                buf_rd_en  = 1'b1;
                send_cnt_d = IDX_W'(1);
            end
            SEND: begin
                if (send_cnt_q == SEND_LEN) begin
                    state_d = WAIT_SOF;
                end else begin
                    buf_rd_en  = 1'b1;
                    send_cnt_d = send_cnt_q + IDX_W'(1);
                end
            end
            default: state_d = WAIT_SOF;
        endcase
    end

    // Registered output decode from the upcoming state.
    always_comb begin
        rx_ready_d     = is_rx_state(state_d);
        game_start_d   = (state_d == START);
        input_enable_d = buf_rd_en;
    end

    // Game progress: busy from the end of a replay until output_valid falls.
    always_comb begin
        game_busy_d = game_busy_q;
        if (ov_prev_q && !game_output_valid) begin
            game_busy_d = 1'b0;
        end
        if ((state_q == SEND) && (send_cnt_q == SEND_LEN)) begin
            game_busy_d = 1'b1;
        end
    end

    assign rx_ready          = rx_ready_q;
    assign game_start        = game_start_q;
    assign game_input_enable = input_enable_q;
    assign frame_err         = frame_err_q;
    assign busy              = !is_rx_state(state_q) || game_busy_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_lockpick_frame_loader.sv
// Directed bench for lockpick_frame_loader.
module tb_lockpick_frame_loader;

    localparam int P = 64;

    logic       clk;
    logic       rst;
    logic       rx_valid;
    logic [7:0] rx_data;
    logic       rx_ready;
    logic       game_output_valid;
    logic [1:0] game_status;
    logic       game_start;
    logic       game_input_enable;
    logic [7:0] game_input_data;
    logic       frame_err;
    logic       busy;
    logic [2:0] dbg_state;

    int errors;
    int checks;

    // Monitor state
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int start_cnt, run_cnt, err_cnt, idle_data_bad;
    int start_cyc, first_cyc, cyc;
    logic en_prev;

    lockpick_frame_loader dut (
        .clk               (clk),
        .rst               (rst),
        .rx_valid          (rx_valid),
        .rx_data           (rx_data),
        .rx_ready          (rx_ready),
        .game_output_valid (game_output_valid),
        .game_status       (game_status),
        .game_start        (game_start),
        .game_input_enable (game_input_enable),
        .game_input_data   (game_input_data),
        .frame_err         (frame_err),
        .busy              (busy),
        .dbg_state         (dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Passive monitor on the falling edge
    always @(negedge clk) begin
        if (game_start === 1'b1) begin
            start_cnt++;
            start_cyc = cyc;
        end
        if (game_input_enable === 1'b1) begin
            if (!en_prev) run_cnt++;
            if (got_q.size() == 0) first_cyc = cyc;
            got_q.push_back(game_input_data);
        end else if (game_input_data !== 8'h00) begin
            idle_data_bad++;
        end
        if (frame_err === 1'b1) err_cnt++;
        en_prev = (game_input_enable === 1'b1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        got_q.delete();
        exp_q.delete();
        start_cnt = 0;
        run_cnt = 0;
        err_cnt = 0;
        idle_data_bad = 0;
        start_cyc = -1;
        first_cyc = -100;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data  = b;
        tick();
        rx_valid = 1'b0;
        rx_data  = 8'h00;
    endtask

    // SOF, first payload byte, 63 zero bytes, checksum byte
    task automatic send_frame(input logic [7:0] first, input logic [7:0] csum);
        send_byte(8'hA5);
        send_byte(first);
        repeat (P - 1) send_byte(8'h00);
        send_byte(csum);
    endtask

    task automatic fill_exp(input logic [7:0] first);
        exp_q.push_back(first);
        repeat (P - 1) exp_q.push_back(8'h00);
    endtask

    // Wait (bounded) until a full burst has been captured and enable has dropped
    task automatic wait_burst(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (got_q.size() >= P && game_input_enable === 1'b0) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    function automatic int burst_mismatch();
        int n;
        n = (got_q.size() == exp_q.size()) ? 0 : 1;
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            if (got_q[i] !== exp_q[i]) n++;
        return n;
    endfunction

    // Game raises output_valid for a few cycles and drops it
    task automatic game_finish(input logic [1:0] st);
        game_status = st;
        game_output_valid = 1'b1;
        repeat (3) tick();
        game_output_valid = 1'b0;
        repeat (2) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rx_valid = 1'b0;
        rx_data = 8'h00;
        game_output_valid = 1'b0;
        game_status = 2'b00;
        repeat (3) tick();
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL reset_rx_ready got=%b exp=0", rx_ready); end
        checks++; if (game_start !== 1'b0) begin errors++; $display("FAIL reset_start got=%b exp=0", game_start); end
        checks++; if (game_input_enable !== 1'b0) begin errors++; $display("FAIL reset_enable got=%b exp=0", game_input_enable); end
        checks++; if (game_input_data !== 8'h00) begin errors++; $display("FAIL reset_data got=%h exp=00", game_input_data); end
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state got=%0d exp=0", dbg_state); end
        rst = 1'b0;
        tick();
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL release_rx_ready got=%b exp=1", rx_ready); end
    endtask

    task automatic test_good_frame();
        bit ok;
        clear_mon();
        fill_exp(8'h5A);
        send_frame(8'h5A, 8'h5A);
        checks++; if (rx_ready !== 1'b0) begin errors++; $display("FAIL good_rx_ready_hold got=%b exp=0", rx_ready); end
        checks++; if (dbg_state !== 3'd3) begin errors++; $display("FAIL good_wait_game got=%0d exp=3", dbg_state); end
        wait_burst(ok);
        checks++; if (!ok) begin errors++; $display("FAIL good_burst_timeout got=%0d bytes exp=%0d", got_q.size(), P); end
        checks++; if (start_cnt !== 1) begin errors++; $display("FAIL good_start_count got=%0d exp=1", start_cnt); end
        checks++; if (first_cyc !== start_cyc + 1) begin errors++; $display("FAIL good_start_to_data got=%0d exp=1", first_cyc - start_cyc); end
        checks++; if (burst_mismatch() !== 0) begin errors++; $display("FAIL good_burst_data got=%0d mismatches exp=0", burst_mismatch()); end
        checks++; if (run_cnt !== 1) begin errors++; $display("FAIL good_no_gaps got=%0d runs exp=1", run_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL good_frame_err got=%0d exp=0", err_cnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL good_busy_after got=%b exp=1", busy); end
        game_finish(2'b00);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL good_busy_clear got=%b exp=0", busy); end
        checks++; if (idle_data_bad !== 0) begin errors++; $display("FAIL good_idle_data got=%0d exp=0", idle_data_bad); end
    endtask

    task automatic test_bad_csum();
        clear_mon();
        send_frame(8'h5A, 8'h5B);
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL bad_err_pulse got=%b exp=1", frame_err); end
        checks++; if (rx_ready !== 1'b1) begin errors++; $display("FAIL bad_rx_ready got=%b exp=1", rx_ready); end
        tick();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL bad_err_width got=%b exp=0", frame_err); end
        repeat (20) tick();
        checks++; if (start_cnt !== 0 || got_q.size() !== 0) begin errors++; $display("FAIL bad_no_start got=%0d/%0d exp=0/0", start_cnt, got_q.size()); end
        checks++; if (dbg_state !== 3'd0 || busy !== 1'b0) begin errors++; $display("FAIL bad_idle got=%0d/%b exp=0/0", dbg_state, busy); end
    endtask

    task automatic test_timeout();
        clear_mon();
        send_byte(8'hA5);
        for (int i = 0; i < 10; i++) send_byte(8'(i + 1));
        repeat (1023) tick();
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL to_early got=%b exp=0", frame_err); end
        tick();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL to_pulse got=%b exp=1", frame_err); end
        checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL to_state got=%0d exp=0", dbg_state); end
        // Byte on the limit cycle wins and restarts the count
        send_byte(8'hA5);
        for (int i = 0; i < 10; i++) send_byte(8'(i + 1));
        repeat (1023) tick();
        send_byte(8'h11);
        checks++; if (frame_err !== 1'b0) begin errors++; $display("FAIL to_byte_wins got=%b exp=0", frame_err); end
        repeat (1023) tick();
        checks++; if (frame_err !== 1'b0 || dbg_state !== 3'd1) begin errors++; $display("FAIL to_restart got=%b/%0d exp=0/1", frame_err, dbg_state); end
        tick();
        checks++; if (frame_err !== 1'b1) begin errors++; $display("FAIL to_second_pulse got=%b exp=1", frame_err); end
        tick();
        checks++; if (err_cnt !== 2) begin errors++; $display("FAIL to_err_count got=%0d exp=2", err_cnt); end
    endtask

    task automatic test_retry_queue();
        bit ok;
        clear_mon();
        send_frame(8'h5A, 8'h5A);
        wait_burst(ok);
        checks++; if (!ok || start_cnt !== 1) begin errors++; $display("FAIL rq_first_frame got=%b/%0d exp=1/1", ok, start_cnt); end
        // Game busy with output_valid high and a retry status
        game_output_valid = 1'b1;
        game_status = 2'b01;
        clear_mon();
        fill_exp(8'h33);
        send_frame(8'h33, 8'h33);
        repeat (10) tick();
        checks++; if (got_q.size() !== 0) begin errors++; $display("FAIL rq_held got=%0d bytes exp=0", got_q.size()); end
        checks++; if (dbg_state !== 3'd3 || busy !== 1'b1) begin errors++; $display("FAIL rq_wait_game got=%0d/%b exp=3/1", dbg_state, busy); end
        game_output_valid = 1'b0;
        wait_burst(ok);
        checks++; if (!ok) begin errors++; $display("FAIL rq_burst_timeout got=%0d bytes exp=%0d", got_q.size(), P); end
        checks++; if (start_cnt !== 0) begin errors++; $display("FAIL rq_no_start got=%0d exp=0", start_cnt); end
        checks++; if (burst_mismatch() !== 0) begin errors++; $display("FAIL rq_burst_data got=%0d mismatches exp=0", burst_mismatch()); end
    endtask

    task automatic test_win_hold();
        bit ok;
        game_finish(2'b10);
        clear_mon();
        fill_exp(8'h77);
        send_frame(8'h77, 8'h77);
        repeat (20) tick();
        checks++; if (dbg_state !== 3'd3 || start_cnt !== 0 || got_q.size() !== 0) begin
            errors++; $display("FAIL win_hold got=%0d/%0d/%0d exp=3/0/0", dbg_state, start_cnt, got_q.size());
        end
        game_status = 2'b00;
        wait_burst(ok);
        checks++; if (!ok || start_cnt !== 1) begin errors++; $display("FAIL win_start got=%b/%0d exp=1/1", ok, start_cnt); end
        checks++; if (first_cyc !== start_cyc + 1) begin errors++; $display("FAIL win_start_to_data got=%0d exp=1", first_cyc - start_cyc); end
        checks++; if (burst_mismatch() !== 0) begin errors++; $display("FAIL win_burst_data got=%0d mismatches exp=0", burst_mismatch()); end
    endtask

    task automatic test_garbage();
        bit ok;
        game_finish(2'b00);
        clear_mon();
        fill_exp(8'hC3);
        send_byte(8'h00);
        send_byte(8'hFF);
        send_byte(8'hA4);
        checks++; if (dbg_state !== 3'd0 || rx_ready !== 1'b1) begin errors++; $display("FAIL gb_dropped got=%0d/%b exp=0/1", dbg_state, rx_ready); end
        send_frame(8'hC3, 8'hC3);
        wait_burst(ok);
        checks++; if (!ok || start_cnt !== 1) begin errors++; $display("FAIL gb_start got=%b/%0d exp=1/1", ok, start_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL gb_no_err got=%0d exp=0", err_cnt); end
        checks++; if (burst_mismatch() !== 0) begin errors++; $display("FAIL gb_burst_data got=%0d mismatches exp=0", burst_mismatch()); end
    endtask

    task automatic test_reset_mid_send();
        game_finish(2'b00);
        clear_mon();
        send_frame(8'h5A, 8'h5A);
        for (int i = 0; i < 50 && game_input_enable !== 1'b1; i++) tick();
        tick();
        checks++; if (game_input_enable !== 1'b1) begin errors++; $display("FAIL rms_in_send got=%b exp=1", game_input_enable); end
        rst = 1'b1;
        #1;
        checks++; if (game_input_enable !== 1'b0 || game_input_data !== 8'h00) begin
            errors++; $display("FAIL rms_outputs got=%b/%h exp=0/00", game_input_enable, game_input_data);
        end
        checks++; if (busy !== 1'b0 || rx_ready !== 1'b0 || game_start !== 1'b0) begin
            errors++; $display("FAIL rms_ctrl got=%b/%b/%b exp=0/0/0", busy, rx_ready, game_start);
        end
        tick();
        rst = 1'b0;
        tick();
    endtask

    initial begin
        errors = 0;
        checks = 0;
        cyc = 0;
        en_prev = 1'b0;
        clear_mon();
        test_reset();
        test_good_frame();
        test_bad_csum();
        test_timeout();
        test_retry_queue();
        test_win_hold();
        test_garbage();
        test_reset_mid_send();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
